// File: rtl/piso_tx_shift_reg_if.sv
// Load/serial bundle for piso_tx_shift_reg.
// master: parallel producer side (drives word, valid, stall).
// slave : transmitter side (drives ready and the serial outputs).
interface piso_tx_shift_reg_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] d;
  logic             load_valid;
  logic             load_ready;
  logic             stall;
  logic             q;
  logic             frame;
  logic             done;

  modport master (output d, load_valid, stall,
                  input  load_ready, q, frame, done);
  modport slave  (input  d, load_valid, stall,
                  output load_ready, q, frame, done);
endinterface

// File: rtl/piso_tx_shift_reg.sv
// Parallel-in serial-out transmitter.
// A word is taken in IDLE through load_valid/load_ready. It is sent one bit
// per clock on q, with frame high for each payload bit and a one-cycle done
// after the last bit. stall freezes the shifter while in SHIFT.
// Optional macro PISO_TX_PARITY_EN appends an even-parity bit to each frame.
module piso_tx_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic               clk,
  input logic               rst,
  piso_tx_shift_reg_if.slave bus
);
`ifdef PISO_TX_PARITY_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state;
  logic [N-1:0]     sreg;
  logic [N-1:0]     word;
  logic [WIDTH-1:0] ord;
  logic [CW-1:0]    cnt;
  logic             q_r, frame_r, done_r;

  // Put the first bit on the wire at the MSB so the shifter always drains left
  always_comb begin
    ord = bus.d;
    if (!MSB_FIRST)
      for (int i = 0; i < WIDTH; i++) ord[i] = bus.d[WIDTH-1-i];
  end

`ifdef PISO_TX_PARITY_EN
  // Parity is fixed at load time and rides behind the last data bit
  assign word = {ord, ^bus.d};
`else
  assign word = ord;
`endif

  assign bus.load_ready = (state == IDLE);
  assign bus.q          = q_r;
  assign bus.frame      = frame_r;
  assign bus.done       = done_r;

  // Load, shift, end-of-frame; reset wins over everything
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      q_r     <= 1'b1;
      frame_r <= 1'b0;
      done_r  <= 1'b0;
      sreg    <= '0;
      cnt     <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load_valid) begin
            state   <= SHIFT;
            q_r     <= word[N-1];
            frame_r <= 1'b1;
            sreg    <= {word[N-2:0], 1'b0};
            cnt     <= '0;
          end
        end
        SHIFT: begin
          if (!bus.stall) begin
            if (cnt == LAST) begin
              state   <= IDLE;
              q_r     <= 1'b1;
              frame_r <= 1'b0;
              done_r  <= 1'b1;
              cnt     <= '0;
            end else begin
              q_r  <= sreg[N-1];
              sreg <= {sreg[N-2:0], 1'b0};
              cnt  <= cnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_piso_tx_shift_reg.sv
// Bench for piso_tx_shift_reg: an MSB-first and an LSB-first instance share
// the same stimulus; a scoreboard of expected bit pairs is checked by a
// negedge monitor, with directed checks for timing, stall and reset.
module tb_piso_tx_shift_reg;
  localparam int W = 8;
`ifdef PISO_TX_PARITY_EN
  localparam int N = W + 1;
`else
  localparam int N = W;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [W-1:0] d = '0;
  logic lv = 1'b0;
  logic st = 1'b0;
  always #5 clk = ~clk;

  piso_tx_shift_reg_if #(.WIDTH(W)) bm ();
  piso_tx_shift_reg_if #(.WIDTH(W)) bl ();
  assign bm.d = d;  assign bm.load_valid = lv;  assign bm.stall = st;
  assign bl.d = d;  assign bl.load_valid = lv;  assign bl.stall = st;

  piso_tx_shift_reg #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(bm));
  piso_tx_shift_reg #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(bl));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit [1:0] exp_q[$];  // {msb_first_bit, lsb_first_bit}
  int exp_len[$];
  bit held = 1'b0;
  bit last_m, last_l;
  int run = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Independent model of the bit order each instance must produce
  task automatic push_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) exp_q.push_back({w[W-1-i], w[i]});
`ifdef PISO_TX_PARITY_EN
    exp_q.push_back({^w, ^w});
`endif
    exp_len.push_back(N);
  endtask

  task automatic send(input logic [W-1:0] w, output int acc);
    bit ok;
    ok = 1'b0;
    acc = -1;
    d = w; lv = 1'b1;
    push_word(w);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bm.load_ready === 1'b1) begin
        @(posedge clk); #1;
        lv = 1'b0; acc = cyc; ok = 1'b1;
        break;
      end
    end
    chk("load_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bm.done === 1'b1) begin ok = 1'b1; break; end
    end
    chk("done_timeout", 32'(ok), 32'd1);
  endtask

  // Scoreboard monitor: pops one pair per fresh payload bit
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete(); exp_len.delete(); run = 0; held = 1'b0;
    end else begin
      bit [1:0] e;
      chk("frame_match", 32'(bl.frame), 32'(bm.frame));
      chk("done_match", 32'(bl.done), 32'(bm.done));
      if (held) begin
        chk("hold_q_m", 32'(bm.q), 32'(last_m));
        chk("hold_q_l", 32'(bl.q), 32'(last_l));
        chk("hold_frame", 32'(bm.frame), 32'd1);
      end else if (bm.frame === 1'b1) begin
        if (exp_q.size() == 0) chk("unexpected_bit", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("q_msb_first", 32'(bm.q), 32'(e[1]));
          chk("q_lsb_first", 32'(bl.q), 32'(e[0]));
          last_m = e[1]; last_l = e[0];
          run++;
        end
      end
      if (bm.done === 1'b1) begin
        chk("done_frame_low", 32'(bm.frame), 32'd0);
        chk("done_ready", 32'(bm.load_ready), 32'd1);
        if (exp_len.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else chk("frame_bits", 32'(run), 32'(exp_len.pop_front()));
        run = 0;
      end
      held = st && (bm.frame === 1'b1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000");
    $fatal(1);
  end

  initial begin
    int a1, a2, fc, dn;
    // Reset state
    tick(); tick();
    chk("rst_q", 32'(bm.q), 32'd1);
    chk("rst_frame", 32'(bm.frame), 32'd0);
    chk("rst_done", 32'(bm.done), 32'd0);
    chk("rst_ready", 32'(bm.load_ready), 32'd1);
    chk("rst_q_l", 32'(bl.q), 32'd1);
    rst = 1'b1;
    tick();

    // 0x0F: frame exactly N cycles, busy while shifting, one-cycle done
    send(8'h0F, a1);
    for (int i = 0; i < N; i++) begin
      chk("busy_ready", 32'(bm.load_ready), 32'd0);
      chk("busy_frame", 32'(bm.frame), 32'd1);
      tick();
    end
    chk("end_done", 32'(bm.done), 32'd1);
    chk("end_q", 32'(bm.q), 32'd1);
    chk("end_frame", 32'(bm.frame), 32'd0);
    tick();
    chk("done_one_cycle", 32'(bm.done), 32'd0);
    tick();

    // Back-to-back: second word held during the first frame
    send(8'h0F, a1);
    send(8'hF0, a2);
    chk("b2b_gap", 32'(a2 - a1), 32'(N + 1));
    wait_done();
    tick();

    // Stall for three cycles while bit 3 is on q
    send(8'hA5, a1);
    fc = 0; dn = -1;
    for (int i = 0; i < 40; i++) begin
      if (bm.done === 1'b1) begin dn = i; break; end
      if (bm.frame === 1'b1) fc++;
      if (i >= 4 && i <= 6) chk("stall_ready", 32'(bm.load_ready), 32'd0);
      if (i == 3) st = 1'b1;
      if (i == 6) st = 1'b0;
      tick();
    end
    chk("stall_frame_len", 32'(fc), 32'(N + 3));
    chk("stall_done_at", 32'(dn), 32'(N + 3));
    tick();

    // stall in IDLE is ignored
    st = 1'b1;
    send(8'h3C, a1);
    tick();
    st = 1'b0;
    wait_done();
    tick();

    // Reset while bit 5 is on q aborts the frame
    send(8'h5C, a1);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("abort_q", 32'(bm.q), 32'd1);
    chk("abort_frame", 32'(bm.frame), 32'd0);
    chk("abort_done", 32'(bm.done), 32'd0);
    chk("abort_ready", 32'(bm.load_ready), 32'd1);
    tick();
    chk("abort_no_done", 32'(bm.done), 32'd0);
    send(8'hAA, a1);
    wait_done();
    tick();

    // Parity cases (odd / even ones count)
    send(8'h07, a1);
    wait_done();
    tick();
    send(8'h03, a1);
    wait_done();
    tick(); tick();

    chk("sb_bits_left", 32'(exp_q.size()), 32'd0);
    chk("sb_frames_left", 32'(exp_len.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/piso_tx_shift_reg.md
Name: piso_tx_shift_reg

Overview:
- Parallel-in, serial-out transmitter, built on the team's synchronous-reset D flip-flops.
- Accepts a WIDTH-bit word through a valid/ready load handshake.
- Drives the word onto a single serial line, one bit per clock, with a frame qualifier and an end-of-word pulse.
- Transmit-side counterpart to the serial-in/parallel-out capture registers; sits between a parallel producer and a serial link.

Parameters:
- WIDTH, 8, data word width in bits, minimum 2.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
- clk  in  1  clock; all state updates on the posedge.
- rst  in  1  reset, synchronous, active-low; sampled only on the posedge of clk.
- d  in  WIDTH  parallel word to transmit.
- load_valid  in  1  producer has a word on d.
- load_ready  out  1  transmitter can accept a word; high only in IDLE.
- stall  in  1  when high in SHIFT, freezes the shift register, bit counter and q.
- q  out  1  serial data line, registered.
- frame  out  1  high while q carries a payload bit, registered.
- done  out  1  one-cycle pulse, registered, in the cycle after the final bit.

Behaviour:
- Reset:
  - rst=0 at a clk edge → state=IDLE, q=1 (line idles high), frame=0, done=0, shift register=0, counter=0.
  - Reset has priority over load_valid, stall and any frame in progress.
- States:
  - IDLE: load_ready=1 (decoded from state). No other states assert load_ready.
  - SHIFT.
- Load:
  - In IDLE, load_valid=1 at edge k captures d and moves to SHIFT.
  - The first payload bit appears on q in cycle k+1 with frame=1.
- Bit order and shifting:
  - MSB_FIRST=1: d[WIDTH-1] first. MSB_FIRST=0: d[0] first.
  - Each non-stalled edge in SHIFT advances to the next bit.
  - The counter runs 0..N-1, where N is the frame length (WIDTH, or WIDTH+1 with the optional feature).
  - Counter width is clog2(N+1).
- End of frame:
  - The edge ending bit N-1 moves the state to IDLE and sets q=1, frame=0, done=1.
  - done lasts exactly one cycle.
  - load_ready=1 during that done cycle, so a back-to-back load is accepted there.
  - Minimum inter-frame gap is one idle cycle.
- Stall:
  - stall=1 in SHIFT holds q, frame, counter and shift register unchanged; frame stays 1.
  - stall is ignored in IDLE.
  - stall on the final bit delays done until the edge after stall drops.
- Reset mid-frame: aborts the frame. Next cycle shows IDLE outputs with done=0; no partial done is ever emitted.
- load_valid while in SHIFT is ignored; the word is not captured.
- Simultaneous done cycle and load_valid=1: the new word is captured; done still pulses for the old word.

Optional Feature:
- Macro: PISO_TX_PARITY_EN.
- Defined:
  - N=WIDTH+1.
  - After the last data bit, one even-parity bit is sent: XOR of all WIDTH captured bits, computed at load.
  - frame stays high for the parity bit; done follows the parity bit.
- Undefined:
  - N=WIDTH, no parity logic present.
  - done follows the last data bit.

Test Plan:
- WIDTH=8, MSB_FIRST=1, load 0x0F at edge k → q=0,0,0,0,1,1,1,1 in cycles k+1..k+8; frame=1 for exactly those 8 cycles; done=1 only in cycle k+9.
- MSB_FIRST=0, load 0x0F → q=1,1,1,1,0,0,0,0; load_ready=0 in cycles k+1..k+8.
- Back-to-back: 0x0F, then load_valid held with 0xF0 → second word captured in the done cycle; bits of 0xF0 start two cycles after the last 0x0F bit; both frames are complete.
- stall=1 for 3 cycles while bit 3 is on q → q and frame held 3 extra cycles; frame lasts 11 cycles total; done is delayed by 3.
- rst=0 for one edge during bit 5 → next cycle q=1, frame=0, done=0, load_ready=1; a new 0xAA load then transmits correctly.
- PISO_TX_PARITY_EN defined, load 0x07 → 8 data bits then parity bit 1; frame high 9 cycles. Load 0x03 → parity bit 0.
